// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: stage 1 registers operands/controls, stage 2 computes and registers
// result and flags. Valid/ready on both sides, with back-pressure from out_ready.
module alu_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       ALU_control,
    input  logic [2:0]       bonus_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [1:0] OpAnd = 2'b00;
    localparam logic [1:0] OpOr  = 2'b01;
    localparam logic [1:0] OpAdd = 2'b10;
    localparam logic [1:0] OpSet = 2'b11;

    // Stage 1 state
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [2:0]       bonus_q, bonus_d;

    // Stage 2 state
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic             adv, s1_load;
    logic [WIDTH-1:0] a_p, b_p, sum, alu_res;
    logic             carry, lt, eq, set_bit;

    assign adv      = ~out_valid_q | out_ready;
    assign s1_load  = ~s1_valid_q | adv;
    assign in_ready = s1_load;

    // Datapath on the stage-1 registers
    always_comb begin
        a_p          = ctrl_q[3] ? ~a_q : a_q;
        b_p          = ctrl_q[2] ? ~b_q : b_q;
        {carry, sum} = {1'b0, a_p} + {1'b0, b_p} + {{WIDTH{1'b0}}, ctrl_q[2]};
        // Same outcome as the msb rule on src1-src2: differing signs decide, else the diff sign.
        lt           = $signed(a_q) < $signed(b_q);
        eq           = (a_q == b_q);
        case (bonus_q)
            3'b000:  set_bit = lt;
            3'b001:  set_bit = ~lt;
            3'b010:  set_bit = lt | eq;
            3'b011:  set_bit = ~lt & ~eq;
            3'b100:  set_bit = ~eq;
            3'b110:  set_bit = eq;
            default: set_bit = 1'b0;
        endcase
        case (ctrl_q[1:0])
            OpAnd:   alu_res = a_p & b_p;
            OpOr:    alu_res = a_p | b_p;
            OpAdd:   alu_res = sum;
            OpSet:   alu_res = {{(WIDTH-1){1'b0}}, set_bit};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        a_d         = a_q;
        b_d         = b_q;
        ctrl_d      = ctrl_q;
        bonus_d     = bonus_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        op_count_d  = op_count_q;

        if (s1_load) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                a_d     = src1;
                b_d     = src2;
                ctrl_d  = ALU_control;
                bonus_d = bonus_control;
            end
        end

        // A bubble clears out_valid but leaves the last result on the outputs
        if (adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d = alu_res;
                zero_d   = ~|alu_res;
                cout_d   = (ctrl_q[1:0] == OpAdd) & carry;
                ovf_d    = (ctrl_q[1:0] == OpAdd) & (a_p[WIDTH-1] == b_p[WIDTH-1]) &
                           (sum[WIDTH-1] != a_p[WIDTH-1]);
            end
        end

        if (out_valid_q && out_ready) begin
            op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            ctrl_q      <= '0;
            bonus_q     <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            op_count_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ctrl_q      <= ctrl_d;
            bonus_q     <= bonus_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            op_count_q  <= op_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: queue of hand-computed expected beats checked at the output,
// plus latency, stall, mid-flight reset and counter-wrap checks.
module tb_alu_pipe;

    localparam int W  = 32;
    localparam int CW = 4;

    localparam logic [3:0] CAnd  = 4'b0000;
    localparam logic [3:0] COr   = 4'b0001;
    localparam logic [3:0] CAdd  = 4'b0010;
    localparam logic [3:0] CSub  = 4'b0110;
    localparam logic [3:0] CNor  = 4'b1100;
    localparam logic [3:0] CNand = 4'b1101;
    localparam logic [3:0] CSet  = 4'b0111;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  src1, src2, result;
    logic [3:0]    alu_ctrl;
    logic [2:0]    bonus;
    logic          zero, cout, overflow;
    logic [CW-1:0] op_count;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [W+2:0]  exp_q[$];
    logic [W+2:0]  head;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .src1          (src1),
        .src2          (src2),
        .ALU_control   (alu_ctrl),
        .bonus_control (bonus),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .zero          (zero),
        .cout          (cout),
        .overflow      (overflow),
        .op_count      (op_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic send(input logic [3:0] c, input logic [2:0] bc, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] er, input logic ec,
                        input logic eo);
        bit done = 1'b0;
        exp_q.push_back({er, (er == '0), ec, eo});
        alu_ctrl = c;
        bonus    = bc;
        src1     = a;
        src2     = b;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        check("accept", done, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        check("drain", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Output monitor: every valid beat is compared against the queue head, repeatedly while stalled.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", out_valid, 0);
            end else begin
                head = exp_q[0];
                check("result", result, head[W+2:3]);
                check("zero", zero, head[2]);
                check("cout", cout, head[1]);
                check("overflow", overflow, head[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        src1      = '0;
        src2      = '0;
        alu_ctrl  = '0;
        bonus     = '0;

        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_result", result, 0);
        check("rst_zero", zero, 1);
        check("rst_cout", cout, 0);
        check("rst_overflow", overflow, 0);
        check("rst_op_count", op_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Latency: accepted at edge 1, valid after edge 2
        send(CAdd, 3'b000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1);
        @(negedge clk);
        check("lat1_out_valid", out_valid, 0);
        @(negedge clk);
        check("lat2_out_valid", out_valid, 1);
        @(posedge clk);
        #1;

        send(CSub,  3'b000, 32'd5,        32'd5,        32'h0,        1'b1, 1'b0);
        send(CAnd,  3'b000, 32'hF0F0,     32'h0FF0,     32'h00F0,     1'b0, 1'b0);
        send(COr,   3'b000, 32'hA5,       32'h5A,       32'hFF,       1'b0, 1'b0);
        send(CNor,  3'b000, 32'h0,        32'h0,        32'hFFFF_FFFF, 1'b0, 1'b0);
        send(CNand, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,      1'b0, 1'b0);
        send(CSet,  3'b000, 32'hFFFF_FFFF, 32'd1,       32'd1,        1'b0, 1'b0);
        send(CSet,  3'b011, 32'hFFFF_FFFF, 32'd1,       32'd0,        1'b0, 1'b0);
        send(CSet,  3'b110, 32'hFFFF_FFFF, 32'd1,       32'd0,        1'b0, 1'b0);
        send(CSet,  3'b101, 32'hFFFF_FFFF, 32'd1,       32'd0,        1'b0, 1'b0);
        send(CSet,  3'b010, 32'd7,        32'd7,        32'd1,        1'b0, 1'b0);
        send(CSet,  3'b100, 32'd7,        32'd7,        32'd0,        1'b0, 1'b0);
        send(CSet,  3'b001, 32'd9,        32'd3,        32'd1,        1'b0, 1'b0);
        send(CSet,  3'b001, 32'd3,        32'd9,        32'd0,        1'b0, 1'b0);
        drain();
        check("op_count_basic", op_count, 14);

        // Back-to-back ADDs with out_ready low for four edges
        do_reset();
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(CAdd, 3'b000, i, 32'h100, 32'h100 + i, 1'b0, 1'b0);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                check("full_in_ready", in_ready, 0);
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("op_count_stall", op_count, 8);

        // Reset with two beats in flight
        out_ready = 1'b0;
        send(CAdd, 3'b000, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
        send(CAdd, 3'b000, 32'd4, 32'd5, 32'd9, 1'b0, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_op_count", op_count, 0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("postrst_out_valid", out_valid, 0);
        end
        check("postrst_op_count", op_count, 0);
        @(posedge clk);
        #1;

        // Counter wrap with a 4-bit counter
        for (int i = 0; i < 17; i++) send(CAnd, 3'b000, i, i, i, 1'b0, 1'b0);
        drain();
        check("op_count_wrap", op_count, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
